// File: rtl/dc_offset_restore_if.sv
// Sample/offset bus between the DSP chain and the DC offset restore stage.
// The master drives samples and offset loads; the slave returns DAC codes and status.
interface dc_offset_restore_if #(
    parameter int DATA_WIDTH     = 12,
    parameter int CLIP_CNT_WIDTH = 16
);
    logic                        in_valid;
    logic signed [DATA_WIDTH:0]  data_in;
    logic [DATA_WIDTH-1:0]       offset_in;
    logic                        offset_load;
    logic [DATA_WIDTH-1:0]       data_out;
    logic                        out_valid;
    logic                        clip;
    logic [CLIP_CNT_WIDTH-1:0]   clip_count;
    logic                        ramp_done;

    modport master (
        output in_valid, data_in, offset_in, offset_load,
        input  data_out, out_valid, clip, clip_count, ramp_done
    );

    modport slave (
        input  in_valid, data_in, offset_in, offset_load,
        output data_out, out_valid, clip, clip_count, ramp_done
    );
endinterface

// File: rtl/dc_offset_restore.sv
// Re-adds a ramped DC offset to zero-mean samples and saturates to unsigned DAC codes.
// Two-stage pipeline: offset add, then clamp; the offset slews toward its target per accepted sample.
module dc_offset_restore #(
    parameter int DATA_WIDTH     = 12,
    parameter int DEFAULT_OFFSET = 2048,
    parameter int RAMP_STEP      = 1,
    parameter int CLIP_CNT_WIDTH = 16
) (
    input  logic                 adc_clk,
    input  logic                 rst,
    dc_offset_restore_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_RAMP   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // A step larger than the full code range behaves like an instant jump to the target.
    localparam int STEP_SAT = (RAMP_STEP > (1 << DATA_WIDTH)) ? (1 << DATA_WIDTH) : RAMP_STEP;
    localparam logic [DATA_WIDTH:0]   STEP_C      = (DATA_WIDTH+1)'(STEP_SAT);
    localparam logic [DATA_WIDTH-1:0] DEF_OFFSET_C = DATA_WIDTH'(DEFAULT_OFFSET);

    state_t                       state_r;
    state_t                       state_nxt_s;
    logic [DATA_WIDTH-1:0]        cur_offset_r;
    logic [DATA_WIDTH-1:0]        cur_offset_nxt_s;
    logic [DATA_WIDTH-1:0]        target_r;
    logic [DATA_WIDTH-1:0]        target_nxt_s;
    logic [DATA_WIDTH:0]          diff_up_s;
    logic [DATA_WIDTH:0]          diff_dn_s;
    logic                         ramp_done_r;

    logic                         valid1_r;
    logic signed [DATA_WIDTH+1:0] sum_r;
    logic                         sat_hi_s;
    logic                         sat_lo_s;

    logic [DATA_WIDTH-1:0]        data_out_r;
    logic                         out_valid_r;
    logic                         clip_r;
    logic [CLIP_CNT_WIDTH-1:0]    clip_count_r;

    assign diff_up_s = {1'b0, target_r} - {1'b0, cur_offset_r};
    assign diff_dn_s = {1'b0, cur_offset_r} - {1'b0, target_r};

    // Offset slew: move toward the current target by at most one step per accepted sample.
    always_comb begin
        cur_offset_nxt_s = cur_offset_r;
        if (bus.in_valid) begin
            if (target_r > cur_offset_r) begin
                if (diff_up_s > STEP_C) begin
                    cur_offset_nxt_s = cur_offset_r + STEP_C[DATA_WIDTH-1:0];
                end else begin
                    cur_offset_nxt_s = target_r;
                end
            end else if (target_r < cur_offset_r) begin
                if (diff_dn_s > STEP_C) begin
                    cur_offset_nxt_s = cur_offset_r - STEP_C[DATA_WIDTH-1:0];
                end else begin
                    cur_offset_nxt_s = target_r;
                end
            end else begin
                cur_offset_nxt_s = cur_offset_r;
            end
        end else begin
            cur_offset_nxt_s = cur_offset_r;
        end
    end

    // Next-state logic; a load is judged against the post-step offset of the same edge.
    always_comb begin
        state_nxt_s  = state_r;
        target_nxt_s = target_r;
        if (bus.offset_load) begin
            target_nxt_s = bus.offset_in;
        end else begin
            target_nxt_s = target_r;
        end
        case (state_r)
            ST_RAMP: begin
                if (bus.offset_load) begin
                    state_nxt_s = (bus.offset_in == cur_offset_nxt_s) ? ST_LOCKED : ST_RAMP;
                end else if (cur_offset_nxt_s == target_r) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    state_nxt_s = ST_RAMP;
                end
            end
            ST_LOCKED: begin
                if (bus.offset_load && (bus.offset_in != cur_offset_nxt_s)) begin
                    state_nxt_s = ST_RAMP;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_RAMP;
            end
        endcase
    end

    // Offset control registers: state, applied offset, target and lock flag.
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state_r      <= ST_RAMP;
            cur_offset_r <= '0;
            target_r     <= DEF_OFFSET_C;
            ramp_done_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cur_offset_r <= cur_offset_nxt_s;
            target_r     <= target_nxt_s;
            ramp_done_r  <= (state_nxt_s == ST_LOCKED);
        end
    end

    // Stage 1: widen and add the pre-edge applied offset.
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            valid1_r <= 1'b0;
            sum_r    <= '0;
        end else begin
            valid1_r <= bus.in_valid;
            if (bus.in_valid) begin
                sum_r <= $signed({bus.data_in[DATA_WIDTH], bus.data_in})
                       + $signed({2'b00, cur_offset_r});
            end else begin
                sum_r <= sum_r;
            end
        end
    end

    assign sat_lo_s = sum_r[DATA_WIDTH+1];
    assign sat_hi_s = ~sum_r[DATA_WIDTH+1] & sum_r[DATA_WIDTH];

    // Stage 2: clamp to the DAC range, flag clipping and count it without wrapping.
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            data_out_r   <= '0;
            out_valid_r  <= 1'b0;
            clip_r       <= 1'b0;
            clip_count_r <= '0;
        end else begin
            out_valid_r <= valid1_r;
            if (valid1_r) begin
                if (sat_lo_s) begin
                    data_out_r <= '0;
                    clip_r     <= 1'b1;
                end else if (sat_hi_s) begin
                    data_out_r <= '1;
                    clip_r     <= 1'b1;
                end else begin
                    data_out_r <= sum_r[DATA_WIDTH-1:0];
                    clip_r     <= 1'b0;
                end
                if ((sat_lo_s || sat_hi_s) && (clip_count_r != '1)) begin
                    clip_count_r <= clip_count_r + 1'b1;
                end else begin
                    clip_count_r <= clip_count_r;
                end
            end else begin
                data_out_r   <= data_out_r;
                clip_r       <= 1'b0;
                clip_count_r <= clip_count_r;
            end
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.clip       = clip_r;
    assign bus.clip_count = clip_count_r;
    assign bus.ramp_done  = ramp_done_r;

endmodule

// File: tb/tb_dc_offset_restore.sv
// Scoreboard bench for dc_offset_restore: driver pushes expected DAC codes, a monitor pops and compares.
module tb_dc_offset_restore;
    localparam int DW   = 12;
    localparam int STEP = 64;
    localparam int CW   = 4;
    localparam int DEF  = 2048;
    localparam int MAXC = (1 << DW) - 1;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        int data;
        bit clip;
    } exp_t;

    logic adc_clk = 1'b0;
    logic rst     = 1'b0;

    dc_offset_restore_if #(.DATA_WIDTH(DW), .CLIP_CNT_WIDTH(CW)) bus ();

    dc_offset_restore #(
        .DATA_WIDTH(DW), .DEFAULT_OFFSET(DEF), .RAMP_STEP(STEP), .CLIP_CNT_WIDTH(CW)
    ) dut (
        .adc_clk (adc_clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #5 adc_clk = ~adc_clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_cur    = 0;
    int   m_target = DEF;
    int   exp_clip_cnt = 0;
    int   last_data = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference offset after one accepted sample: move toward target, never past it.
    function automatic int ref_step(input int cur, input int tgt);
        if (tgt > cur) return (tgt - cur > STEP) ? cur + STEP : tgt;
        if (tgt < cur) return (cur - tgt > STEP) ? cur - STEP : tgt;
        return cur;
    endfunction

    task automatic drive(input bit v, input int d, input bit ld, input int off);
        exp_t e;
        int   s;
        bus.in_valid    = v;
        bus.data_in     = d[DW:0];
        bus.offset_load = ld;
        bus.offset_in   = off[DW-1:0];
        if (v) begin
            s = d + m_cur;
            if (s < 0) begin e.data = 0; e.clip = 1'b1; end
            else if (s > MAXC) begin e.data = MAXC; e.clip = 1'b1; end
            else begin e.data = s; e.clip = 1'b0; end
            exp_q.push_back(e);
        end
        @(posedge adc_clk);
        #1;
        if (v) m_cur = ref_step(m_cur, m_target);
        if (ld) m_target = off;
        check("ramp_done", {31'd0, bus.ramp_done}, {31'd0, (m_cur == m_target)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0);
    endtask

    task automatic do_reset(input bit v);
        rst             = 1'b1;
        bus.in_valid    = v;
        bus.data_in     = 13'sd5;
        bus.offset_load = 1'b0;
        bus.offset_in   = 12'd0;
        @(posedge adc_clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        m_cur        = 0;
        m_target     = DEF;
        exp_clip_cnt = 0;
        last_data    = 0;
        check("reset out_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("reset data_out",   {20'd0, bus.data_out}, 32'd0);
        check("reset clip",       {31'd0, bus.clip}, 32'd0);
        check("reset clip_count", {28'd0, bus.clip_count}, 32'd0);
        check("reset ramp_done",  {31'd0, bus.ramp_done}, 32'd0);
    endtask

    // Monitor: compare every presented output against the scoreboard; gaps must hold.
    always @(negedge adc_clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected out_valid", {31'd0, bus.out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", {20'd0, bus.data_out}, e.data);
                    check("clip", {31'd0, bus.clip}, {31'd0, e.clip});
                    if (e.clip && exp_clip_cnt < CMAX) exp_clip_cnt++;
                    last_data = e.data;
                end
                check("clip_count", {28'd0, bus.clip_count}, exp_clip_cnt);
            end else begin
                check("gap clip", {31'd0, bus.clip}, 32'd0);
                check("gap hold", {20'd0, bus.data_out}, last_data);
            end
        end
    end

    initial begin
        int done_k;
        bus.in_valid    = 1'b0;
        bus.data_in     = '0;
        bus.offset_in   = '0;
        bus.offset_load = 1'b0;
        do_reset(1'b0);
        mon_en = 1'b1;

        // Start-up ramp from zero to mid-scale.
        done_k = -1;
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 0, 1'b0, 0);
            if (done_k < 0 && bus.ramp_done) done_k = k;
        end
        check("ramp_done rise sample", done_k, 31);
        idle(3);

        // Saturation at both rails.
        drive(1'b1, 2047, 1'b0, 0);
        drive(1'b1, 2048, 1'b0, 0);
        drive(1'b1, -2048, 1'b0, 0);
        drive(1'b1, -2049, 1'b0, 0);
        idle(3);
        check("clip_count after rails", {28'd0, bus.clip_count}, 32'd2);

        // Load concurrent with a sample, then ramp down.
        drive(1'b1, 0, 1'b1, 1000);
        check("ramp_done drop on load", {31'd0, bus.ramp_done}, 32'd0);
        for (int i = 0; i < 24; i++) drive(1'b1, 0, 1'b0, 0);
        check("locked at 1000", {31'd0, bus.ramp_done}, 32'd1);
        idle(2);

        // Gapped ramp upward.
        drive(1'b0, 0, 1'b1, 3000);
        for (int i = 0; i < 30; i++) drive(i[0] == 1'b0, $urandom_range(0, 200) - 100, 1'b0, 0);
        idle(3);

        // Reset with samples in flight mid-ramp.
        drive(1'b1, 7, 1'b0, 0);
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 0, 1'b0, 0);
        idle(3);

        // Randomized traffic with occasional loads.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, $urandom_range(0, 8191) - 4096,
                  ($urandom % 32) == 0, $urandom_range(0, MAXC));
        end
        idle(3);

        // Clip counter saturation.
        do_reset(1'b0);
        for (int i = 0; i < 40; i++) drive(1'b1, 0, 1'b0, 0);
        for (int i = 0; i < 20; i++) drive(1'b1, 4095, 1'b0, 0);
        idle(4);
        check("clip_count saturated", {28'd0, bus.clip_count}, CMAX);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
